// File: rtl/jtframe_upload_pkg.sv
// Shared constants and FSM state type for the MiST upload (FPGA -> ARM) path.
package jtframe_upload_pkg;

  localparam logic [7:0] UIO_UP_START = 8'h5A;
  localparam logic [7:0] UIO_UP_DAT   = 8'h5B;
  localparam logic [7:0] UIO_UP_END   = 8'h5C;

  typedef enum logic [1:0] {
    StCmd,
    StIdx,
    StDat,
    StSkip
  } upload_st_e;

endpackage

// File: rtl/jtframe_mist_upload_if.sv
// ioctl-style read port used by the upload block to fetch game memory.
interface jtframe_mist_upload_if #(
  parameter int unsigned AW = 23
);
  logic [AW-1:0] ioctl_addr;
  logic          ioctl_rd;
  logic [7:0]    ioctl_din;

  modport master (
    output ioctl_addr,
    output ioctl_rd,
    input  ioctl_din
  );

  modport slave (
    input  ioctl_addr,
    input  ioctl_rd,
    output ioctl_din
  );
endinterface

// File: rtl/jtframe_spi_shifter.sv
// SPI mode-0 slave datapath: input synchronisers, SCK edge detect, rx byte assembly and
// tx shifter that loads a new byte on the first SCK fall of each byte.
module jtframe_spi_shifter (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       i_sck,
  input  logic       i_ss_n,
  input  logic       i_di,
  input  logic       i_load_en,
  input  logic [7:0] i_load_data,
  output logic       o_ss_high,
  output logic       o_byte_done,
  output logic [7:0] o_byte,
  output logic       o_do
);

  logic       r_sck_meta, r_sck_sync, r_sck_last;
  logic       r_ss_meta, r_ss_sync;
  logic       r_di_meta, r_di_sync;
  logic [2:0] r_cnt;
  logic [6:0] r_rx;
  logic [7:0] r_tx;
  logic       w_rise, w_fall;

  // Select is reset to the deselected level so the FSM starts parked in StCmd.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_meta <= 1'b0;
      r_sck_sync <= 1'b0;
      r_sck_last <= 1'b0;
      r_ss_meta  <= 1'b1;
      r_ss_sync  <= 1'b1;
      r_di_meta  <= 1'b0;
      r_di_sync  <= 1'b0;
    end else begin
      r_sck_meta <= i_sck;
      r_sck_sync <= r_sck_meta;
      r_sck_last <= r_sck_sync;
      r_ss_meta  <= i_ss_n;
      r_ss_sync  <= r_ss_meta;
      r_di_meta  <= i_di;
      r_di_sync  <= r_di_meta;
    end
  end

  assign w_rise = r_sck_sync & ~r_sck_last & ~r_ss_sync;
  assign w_fall = ~r_sck_sync & r_sck_last & ~r_ss_sync;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 3'd0;
      r_rx  <= 7'd0;
    end else if (r_ss_sync) begin
      r_cnt <= 3'd0;
    end else if (w_rise) begin
      r_cnt <= r_cnt + 3'd1;
      r_rx  <= {r_rx[5:0], r_di_sync};
    end
  end

  // A fall with the bit counter at zero is the first fall of a new byte.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_tx <= 8'd0;
    end else if (w_fall) begin
      if (r_cnt == 3'd0) begin
        r_tx <= i_load_en ? i_load_data : 8'd0;
      end else begin
        r_tx <= {r_tx[6:0], 1'b0};
      end
    end
  end

  assign o_ss_high   = r_ss_sync;
  assign o_byte_done = w_rise & (r_cnt == 3'd7);
  assign o_byte      = {r_rx, r_di_sync};
  assign o_do        = r_tx[7];

endmodule

// File: rtl/jtframe_mist_upload.sv
// Upload FSM: decodes ARM commands on SPI and streams game memory back on SPI_DO, prefetching
// each byte through the ioctl read port one byte ahead of the shifter.
module jtframe_mist_upload
  import jtframe_upload_pkg::*;
#(
  parameter int unsigned AW     = 23,
  parameter int unsigned RD_LAT = 2
) (
  input  logic                  clk_sys,
  input  logic                  rst_n,
  input  logic                  SPI_SCK,
  input  logic                  SPI_SS2,
  input  logic                  SPI_DI,
  output logic                  spi_do,
  output logic                  spi_do_oe,
  jtframe_mist_upload_if.master ioctl,
  output logic [7:0]            ioctl_index,
  output logic                  uploading
);

  upload_st_e    r_state, w_state_nx;
  logic          r_upl, w_upl_nx;
  logic [7:0]    r_idx, w_idx_nx;
  logic [AW-1:0] r_addr, w_addr_nx;
  logic          r_rd, w_start_rd;
  logic          r_pend;
  logic [2:0]    r_lat;
  logic [7:0]    r_buf;
  logic          w_ss_high, w_byte_done, w_do, w_load_en;
  logic [7:0]    w_byte;

  assign w_load_en = (r_state == StDat) & r_upl;

  jtframe_spi_shifter u_shifter (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .i_sck       (SPI_SCK),
    .i_ss_n      (SPI_SS2),
    .i_di        (SPI_DI),
    .i_load_en   (w_load_en),
    .i_load_data (r_buf),
    .o_ss_high   (w_ss_high),
    .o_byte_done (w_byte_done),
    .o_byte      (w_byte),
    .o_do        (w_do)
  );

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StCmd;
      r_upl   <= 1'b0;
      r_idx   <= 8'd0;
      r_addr  <= '0;
      r_rd    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_upl   <= w_upl_nx;
      r_idx   <= w_idx_nx;
      r_addr  <= w_addr_nx;
      r_rd    <= w_start_rd;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_upl_nx   = r_upl;
    w_idx_nx   = r_idx;
    w_addr_nx  = r_addr;
    w_start_rd = 1'b0;
    if (w_ss_high) begin
      w_state_nx = StCmd;
    end else if (w_byte_done) begin
      case (r_state)
        StCmd: begin
          case (w_byte)
            UIO_UP_START: w_state_nx = StIdx;
            UIO_UP_DAT:   w_state_nx = StDat;
            UIO_UP_END: begin
              w_upl_nx   = 1'b0;
              w_state_nx = StSkip;
            end
            default:      w_state_nx = StSkip;
          endcase
        end
        StIdx: begin
          w_idx_nx   = w_byte;
          w_addr_nx  = '0;
          w_upl_nx   = 1'b1;
          w_start_rd = 1'b1;
          w_state_nx = StSkip;
        end
        StDat: begin
          if (r_upl) begin
            w_addr_nx  = r_addr + AW'(1);
            w_start_rd = 1'b1;
          end
        end
        default: w_state_nx = StSkip;
      endcase
    end
  end

  // Latency counter runs independently of SS2 so a read in flight at frame end still lands.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= 1'b0;
      r_lat  <= 3'd0;
      r_buf  <= 8'd0;
    end else if (w_start_rd) begin
      r_pend <= 1'b1;
      r_lat  <= 3'(RD_LAT);
    end else if (r_pend) begin
      if (r_lat == 3'd0) begin
        r_buf  <= ioctl.ioctl_din;
        r_pend <= 1'b0;
      end else begin
        r_lat <= r_lat - 3'd1;
      end
    end
  end

  assign spi_do_oe        = w_load_en;
  assign spi_do           = w_do & w_load_en;
  assign ioctl.ioctl_addr = r_addr;
  assign ioctl.ioctl_rd   = r_rd;
  assign ioctl_index      = r_idx;
  assign uploading        = r_upl;

endmodule

// File: tb/tb_jtframe_mist_upload.sv
// Bench for jtframe_mist_upload: directed command table, model-checked random frames, reset corner.
module tb_jtframe_mist_upload;

  localparam int unsigned AW     = 4;
  localparam int unsigned RD_LAT = 6;
  localparam int unsigned HALF   = 12;
  localparam int unsigned MEMSZ  = 16;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;
  logic sck     = 1'b0;
  logic ss2     = 1'b1;
  logic di      = 1'b0;
  logic       spi_do, spi_do_oe, uploading;
  logic [7:0] ioctl_index;

  jtframe_mist_upload_if #(.AW(AW)) u_if ();

  jtframe_mist_upload #(.AW(AW), .RD_LAT(RD_LAT)) dut (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .SPI_SCK     (sck),
    .SPI_SS2     (ss2),
    .SPI_DI      (di),
    .spi_do      (spi_do),
    .spi_do_oe   (spi_do_oe),
    .ioctl       (u_if),
    .ioctl_index (ioctl_index),
    .uploading   (uploading)
  );

  always #5 clk_sys = ~clk_sys;

  // Memory with exactly RD_LAT cycles of read latency; data is only valid for one cycle.
  logic [7:0] mem [MEMSZ];
  logic       pipe_v [RD_LAT];
  logic [7:0] pipe_d [RD_LAT];
  always @(posedge clk_sys) begin
    pipe_v[0] <= u_if.ioctl_rd;
    pipe_d[0] <= mem[u_if.ioctl_addr];
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
  end
  assign u_if.ioctl_din = pipe_v[RD_LAT-1] ? pipe_d[RD_LAT-1] : 8'hEE;

  logic [AW-1:0] rd_addrs [$];
  int            oe_cnt = 0;
  always @(negedge clk_sys) begin
    if (u_if.ioctl_rd) rd_addrs.push_back(u_if.ioctl_addr);
    if (spi_do_oe) oe_cnt <= oe_cnt + 1;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic spi_bits(input logic [7:0] d, input int nbits, output logic [7:0] r);
    r = 8'd0;
    for (int b = 0; b < nbits; b++) begin
      di = d[7-b];
      wait_clk(HALF);
      sck = 1'b1;
      r = {r[6:0], spi_do};
      wait_clk(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic ss_low();
    ss2 = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic ss_high();
    wait_clk(HALF);
    ss2 = 1'b1;
    wait_clk(2 * HALF);
  endtask

  typedef struct {
    logic [0:5][7:0] b;
    int              n;
    logic            upl;
    logic [7:0]      idx;
    int              nrd;
    logic [AW-1:0]   addr;
    logic            oe;
    logic [0:5][7:0] rx;
  } vec_t;

  // Reference model: stream pointer, upload flag and index as the ARM sees them.
  logic       m_upl;
  logic [7:0] m_idx;
  int         m_ptr;

  task automatic check_state(input string tag);
    check({tag, ".uploading"}, uploading, m_upl);
    check({tag, ".index"}, ioctl_index, m_idx);
    check({tag, ".addr"}, u_if.ioctl_addr, m_ptr % MEMSZ);
  endtask

  task automatic do_start(input logic [7:0] idx);
    logic [7:0] r;
    int rd0;
    rd0 = rd_addrs.size();
    ss_low();
    spi_bits(8'h5A, 8, r);
    spi_bits(idx, 8, r);
    ss_high();
    m_upl = 1'b1;
    m_idx = idx;
    m_ptr = 0;
    check("start.reads", rd_addrs.size() - rd0, 1);
    if (rd_addrs.size() > rd0) check("start.rd_addr", rd_addrs[rd0], 0);
    check_state("start");
  endtask

  task automatic do_data(input int k, input int pbits);
    logic [7:0] r, exp;
    int rd0, exp_n, oe0;
    rd0 = rd_addrs.size();
    oe0 = oe_cnt;
    ss_low();
    spi_bits(8'h5B, 8, r);
    for (int i = 0; i < k; i++) begin
      spi_bits(8'($urandom), 8, r);
      exp = m_upl ? mem[(m_ptr + i) % MEMSZ] : 8'h00;
      check("data.rx", r, exp);
    end
    if (pbits > 0) begin
      spi_bits(8'($urandom), pbits, r);
      exp = m_upl ? (mem[(m_ptr + k) % MEMSZ] >> (8 - pbits)) : 8'h00;
      check("data.partial_rx", r, exp);
    end
    ss_high();
    exp_n = m_upl ? k : 0;
    check("data.reads", rd_addrs.size() - rd0, exp_n);
    for (int i = 0; i < exp_n && rd0 + i < rd_addrs.size(); i++)
      check("data.rd_addr", rd_addrs[rd0+i], (m_ptr + 1 + i) % MEMSZ);
    if (k > 0) check("data.oe", oe_cnt > oe0, m_upl);
    if (m_upl) m_ptr = m_ptr + k;
    check_state("data");
  endtask

  task automatic do_end();
    logic [7:0] r;
    ss_low();
    spi_bits(8'h5C, 8, r);
    ss_high();
    m_upl = 1'b0;
    check_state("end");
  endtask

  task automatic do_other();
    logic [7:0] r, c;
    int rd0;
    rd0 = rd_addrs.size();
    c = 8'($urandom);
    if (c == 8'h5A || c == 8'h5B || c == 8'h5C) c = 8'h53;
    ss_low();
    spi_bits(c, 8, r);
    for (int i = 0; i < 2; i++) spi_bits(8'($urandom), 8, r);
    ss_high();
    check("other.reads", rd_addrs.size() - rd0, 0);
    check_state("other");
  endtask

  vec_t vecs [8];

  initial begin
    logic [7:0] r;
    int rd0, oe0, t;

    vecs[0] = '{{8'h5A, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 1'b1, 8'h03, 1, 4'd0, 1'b0, 48'h0};
    vecs[1] = '{{8'h5B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 5, 1'b1, 8'h03, 4, 4'd4, 1'b1,
                {8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00}};
    vecs[2] = '{{8'h53, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00}, 3, 1'b1, 8'h03, 0, 4'd4, 1'b0, 48'h0};
    vecs[3] = '{{8'h53, 8'h5A, 8'h09, 8'h00, 8'h00, 8'h00}, 3, 1'b1, 8'h03, 0, 4'd4, 1'b0, 48'h0};
    vecs[4] = '{{8'h5A, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 1'b1, 8'h07, 1, 4'd0, 1'b0, 48'h0};
    vecs[5] = '{{8'h5B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, 1'b1, 8'h07, 2, 4'd2, 1'b1,
                {8'h00, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00}};
    vecs[6] = '{{8'h5C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 1'b0, 8'h07, 0, 4'd2, 1'b0, 48'h0};
    vecs[7] = '{{8'h5B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, 1'b0, 8'h07, 0, 4'd2, 1'b0, 48'h0};

    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    for (int i = 4; i < MEMSZ; i++) mem[i] = 8'(8'hA0 + i);

    wait_clk(3);
    check("rst.spi_do", spi_do, 0);
    check("rst.oe", spi_do_oe, 0);
    check("rst.addr", u_if.ioctl_addr, 0);
    check("rst.rd", u_if.ioctl_rd, 0);
    check("rst.index", ioctl_index, 0);
    check("rst.uploading", uploading, 0);
    rst_n = 1'b1;
    wait_clk(4);

    for (int v = 0; v < 8; v++) begin
      rd0 = rd_addrs.size();
      oe0 = oe_cnt;
      ss_low();
      for (int k = 0; k < vecs[v].n; k++) begin
        spi_bits(vecs[v].b[k], 8, r);
        if (vecs[v].b[0] == 8'h5B && k > 0) check($sformatf("vec%0d.rx%0d", v, k), r, vecs[v].rx[k]);
      end
      ss_high();
      check($sformatf("vec%0d.uploading", v), uploading, vecs[v].upl);
      check($sformatf("vec%0d.index", v), ioctl_index, vecs[v].idx);
      check($sformatf("vec%0d.reads", v), rd_addrs.size() - rd0, vecs[v].nrd);
      check($sformatf("vec%0d.addr", v), u_if.ioctl_addr, vecs[v].addr);
      check($sformatf("vec%0d.oe", v), oe_cnt > oe0, vecs[v].oe);
      if (vecs[v].nrd > 0 && rd_addrs.size() > 0)
        check($sformatf("vec%0d.last_rd", v), rd_addrs[rd_addrs.size()-1], vecs[v].addr);
    end

    // Abort mid-byte resumes with the same byte; after END the stream is all zero.
    m_upl = 1'b0; m_idx = 8'h07; m_ptr = 2;
    do_start(8'h01);
    do_data(2, 3);
    do_data(1, 0);
    do_end();
    do_data(1, 0);

    // Address wrap: byte 16 of the stream comes from mem[0].
    for (int i = 0; i < MEMSZ; i++) mem[i] = 8'($urandom);
    do_start(8'h02);
    do_data(17, 0);

    for (int it = 0; it < 12; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (it == 0 || op < 2) do_start(8'($urandom));
      else if (op < 7) do_data($urandom_range(0, 6), ($urandom_range(0, 1) == 1) ? $urandom_range(1, 7) : 0);
      else if (op == 7) do_end();
      else do_other();
    end

    // Reset asserted while a prefetch read is in flight.
    do_start(8'h33);
    ss_low();
    spi_bits(8'h5B, 8, r);
    spi_bits(8'h00, 7, r);
    wait_clk(HALF);
    sck = 1'b1;
    t = 0;
    while (!u_if.ioctl_rd && t < 40) begin
      @(negedge clk_sys);
      t++;
    end
    check("rstmid.rd_seen", t < 40, 1);
    wait_clk(2);
    rst_n = 1'b0;
    wait_clk(1);
    check("rstmid.spi_do", spi_do, 0);
    check("rstmid.oe", spi_do_oe, 0);
    check("rstmid.addr", u_if.ioctl_addr, 0);
    check("rstmid.index", ioctl_index, 0);
    check("rstmid.uploading", uploading, 0);
    sck = 1'b0;
    ss2 = 1'b1;
    wait_clk(2);
    rd0 = rd_addrs.size();
    rst_n = 1'b1;
    wait_clk(20);
    check("rstmid.buf", dut.r_buf, 0);
    check("rstmid.reads", rd_addrs.size() - rd0, 0);
    check("rstmid.uploading_after", uploading, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
